// File: rtl/crossroad_pkg.sv
// Shared definitions for the crossroad phase scheduler: lamp codes, directions, phases.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package crossroad_pkg;

  // Lamp codes {R,Y,G}
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  // Direction indices; bit positions in req/pending follow the same order
  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_W = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_E = 2'd3;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_ALLRED = 2'd3
  } phase_e;

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/crossroad_phase_sched_if.sv
// Signal bundle between the crossroad scheduler and its environment.
// Latency: n/a (wiring only).
// Backpressure: none; tick and req are sampled every cycle, lamps are always valid.
// Optional emergency preemption signals exist when CROSSROAD_EMERG_PREEMPT_EN is defined.
interface crossroad_phase_sched_if;

  logic       tick;
  logic [3:0] req;
  logic [2:0] north_light;
  logic [2:0] west_light;
  logic [2:0] south_light;
  logic [2:0] east_light;
  logic [1:0] active_dir;
  logic [1:0] phase;
`ifdef CROSSROAD_EMERG_PREEMPT_EN
  logic       emg;
  logic [1:0] emg_dir;

  modport master (
    output tick, req, emg, emg_dir,
    input  north_light, west_light, south_light, east_light, active_dir, phase
  );

  modport slave (
    input  tick, req, emg, emg_dir,
    output north_light, west_light, south_light, east_light, active_dir, phase
  );
`else
  modport master (
    output tick, req,
    input  north_light, west_light, south_light, east_light, active_dir, phase
  );

  modport slave (
    input  tick, req,
    output north_light, west_light, south_light, east_light, active_dir, phase
  );
`endif

endinterface

// File: rtl/crossroad_rr_pick.sv
// Round-robin direction picker: first demanding direction after last_dir, wrapping mod 4.
// Latency: purely combinational.
// Backpressure: none; last_dir itself is the lowest-priority candidate (re-grant when alone).
module crossroad_rr_pick (
  input  logic [3:0] dem,
  input  logic [1:0] last_dir,
  output logic [1:0] grant_dir,
  output logic       any
);

  assign any = |dem;

  // Scan from farthest offset to nearest so the nearest demanding direction wins
  always_comb begin
    grant_dir = last_dir;
    for (int i = 4; i >= 1; i--) begin
      if (dem[last_dir + 2'(i)]) grant_dir = last_dir + 2'(i);
    end
  end

endmodule

// File: rtl/crossroad_phase_sched.sv
// Demand-actuated four-way phase scheduler: latched requests, round-robin green, min/max green window.
// Latency: IDLE with demand before edge k shows green after edge k; later phases advance on tick.
// Backpressure: none; requests are latched in pending until served. Preemption: CROSSROAD_EMERG_PREEMPT_EN.
module crossroad_phase_sched
  import crossroad_pkg::*;
#(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 16,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  crossroad_phase_sched_if.slave  bus
);

  localparam int CW = $clog2(GREEN_MAX + 1);

  phase_e          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      pending;
  logic [1:0]      last_dir;

  logic [3:0]      dem;
  logic [3:0]      own_mask;
  logic [3:0]      pending_set;
  logic [1:0]      pick_dir;
  logic            pick_any;
  logic            emg_on;
  logic [1:0]      emg_d;
  logic [1:0]      grant;
  logic            go;
  logic            other_dem;
  logic            min_ok;
  logic            at_max;
  logic            green_hold;
  logic            green_cut;
  logic            green_exit;
  logic            yel_done;
  logic            ar_done;
  logic [2:0]      lamp [4];

`ifdef CROSSROAD_EMERG_PREEMPT_EN
  assign emg_on = bus.emg;
  assign emg_d  = bus.emg_dir;
`else
  assign emg_on = 1'b0;
  assign emg_d  = DIR_N;
`endif

  // A direction's own request is ignored while it holds green, so it does not re-queue itself
  assign own_mask    = (state == PH_GREEN) ? dir_onehot(last_dir) : 4'b0000;
  assign pending_set = pending | (bus.req & ~own_mask);
  assign dem         = pending | bus.req;

  crossroad_rr_pick u_pick (
    .dem       (dem),
    .last_dir  (last_dir),
    .grant_dir (pick_dir),
    .any       (pick_any)
  );

  // An active emergency acts as demand and overrides the round-robin choice
  assign grant = emg_on ? emg_d : pick_dir;
  assign go    = pick_any | emg_on;

  assign other_dem  = |(dem & ~dir_onehot(last_dir));
  assign min_ok     = cnt >= CW'(GREEN_MIN - 1);
  assign at_max     = cnt == CW'(GREEN_MAX - 1);
  assign green_hold = emg_on && (emg_d == last_dir);
  assign green_cut  = emg_on && (emg_d != last_dir);
  assign green_exit = green_cut ||
                      (!green_hold && bus.tick && ((min_ok && other_dem) || at_max));
  assign yel_done   = bus.tick && (cnt == CW'(YELLOW_T - 1));
  assign ar_done    = bus.tick && (cnt == CW'(ALLRED_T - 1));

  // Phase FSM with timer, demand latch and last-served direction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PH_IDLE;
      cnt      <= '0;
      pending  <= 4'b0000;
      last_dir <= DIR_E;
    end else begin
      pending <= pending_set;
      // Saturating at GREEN_MAX-1 only matters for an emergency hold; other phases exit earlier
      if (bus.tick && !at_max) cnt <= cnt + CW'(1);
      case (state)
        PH_IDLE: begin
          if (go) begin
            state    <= PH_GREEN;
            cnt      <= '0;
            last_dir <= grant;
            pending  <= pending_set & ~dir_onehot(grant);
          end
        end
        PH_GREEN: begin
          if (green_exit) begin
            state <= PH_YELLOW;
            cnt   <= '0;
          end
        end
        PH_YELLOW: begin
          if (yel_done) begin
            state <= PH_ALLRED;
            cnt   <= '0;
          end
        end
        PH_ALLRED: begin
          if (ar_done) begin
            cnt <= '0;
            if (go) begin
              state    <= PH_GREEN;
              last_dir <= grant;
              pending  <= pending_set & ~dir_onehot(grant);
            end else begin
              state <= PH_IDLE;
            end
          end
        end
        default: begin
          state <= PH_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Lamp decode from registered state only; at most one lamp can leave red
  always_comb begin
    for (int i = 0; i < 4; i++) lamp[i] = LIGHT_RED;
    if (state == PH_GREEN)  lamp[last_dir] = LIGHT_GRN;
    if (state == PH_YELLOW) lamp[last_dir] = LIGHT_YEL;
  end

  assign bus.north_light = lamp[DIR_N];
  assign bus.west_light  = lamp[DIR_W];
  assign bus.south_light = lamp[DIR_S];
  assign bus.east_light  = lamp[DIR_E];
  assign bus.active_dir  = last_dir;
  assign bus.phase       = state;

endmodule
